// File: rtl/snn_pkg.sv
// Shared types and the output-range helper for the SNN MAC datapath.
// Pure definitions, no state.
// Not applicable: no handshake in this file.
package snn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } mac_state_t;

    // Working width for the range helper; wide enough for any sane accumulator.
    localparam int SAT_VW = 64;

    typedef struct packed {
        logic [SAT_VW-1:0] res;
        logic              ovf;
    } sat_res_t;

    // Fit a signed value into out_w bits: clamp when sat=1, otherwise leave it for the
    // caller to truncate. ovf flags any value outside the signed out_w range.
    function automatic sat_res_t sat_trunc(
        input logic signed [SAT_VW-1:0] v,
        input int                       out_w,
        input logic                     sat
    );
        logic signed [SAT_VW-1:0] hi;
        logic signed [SAT_VW-1:0] lo;
        sat_res_t                 r;
        hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (out_w - 1));
        r.ovf = (v > hi) || (v < lo);
        if (sat && (v > hi)) begin
            r.res = hi;
        end else if (sat && (v < lo)) begin
            r.res = lo;
        end else begin
            r.res = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_sat.sv
// Output stage: optional ReLU, then clamp or truncate the accumulator to OUT_W, flag overflow.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, result captured by the parent on the last term.
module mac_sat
    import snn_pkg::*;
#(
    parameter int ACC_W = 26,
    parameter int OUT_W = 16,
    parameter bit SAT   = 1'b1
) (
    input  logic [ACC_W-1:0] i_sum,
    input  logic             i_relu,
    output logic [OUT_W-1:0] o_res,
    output logic             o_ovf
);

    logic [SAT_VW-1:0] w_v;
    sat_res_t          w_sr;
    logic              w_unused_hi;

    // ReLU zeroes negative sums before range reduction, so a clamped-to-zero result never flags ovf.
    assign w_v = (i_relu && i_sum[ACC_W-1]) ? '0
               : {{(SAT_VW-ACC_W){i_sum[ACC_W-1]}}, i_sum};

    assign w_sr        = sat_trunc(signed'(w_v), OUT_W, SAT);
    assign o_res       = w_sr.res[OUT_W-1:0];
    assign o_ovf       = w_sr.ovf;
    assign w_unused_hi = ^w_sr.res[SAT_VW-1:OUT_W];

endmodule

// File: rtl/mac_pipe.sv
// Two-stage signed multiply-accumulate over framed (a,b) term streams, one result per sequence.
// Latency: last term sampled at edge k -> res_vld pulses in the cycle after edge k+1; 1 term/cycle.
// Backpressure: none; in_vld=0 stalls the sequence, the consumer must take every res_vld pulse.
module mac_pipe
    import snn_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 26,
    parameter int OUT_W = 16,
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_n,
    input  logic                    in_vld,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic                    in_last,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] res,
    output logic                    res_vld,
    output logic                    ovf,
    output logic [CNT_W-1:0]        cnt,
    output logic                    busy
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] r_p;
    logic                  r_p_vld;
    logic                  r_p_last;
    logic                  r_relu_q;
    mac_state_t            r_state;
    logic [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_term_cnt;

    logic [ACC_W-1:0]      w_sum;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [OUT_W-1:0]      w_res;
    logic                  w_ovf;

    // Accumulator wraps modulo 2^ACC_W; the product is sign-extended into it.
    assign w_sum     = r_acc + {{(ACC_W-P_W){r_p[P_W-1]}}, r_p};
    assign w_cnt_inc = (&r_term_cnt) ? r_term_cnt : r_term_cnt + CNT_W'(1);
    assign busy      = (r_state != IDLE) || r_p_vld;

    mac_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SAT   (SAT)
    ) u_sat (
        .i_sum  (w_sum),
        .i_relu (r_relu_q),
        .o_res  (w_res),
        .o_ovf  (w_ovf)
    );

    // Stage 1: register the full-width product and its framing; clear flushes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p      <= '0;
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
            r_relu_q <= 1'b0;
        end else if (!clr_n) begin
            r_p      <= '0;
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
            r_relu_q <= 1'b0;
        end else begin
            r_p_vld <= in_vld;
            if (in_vld) begin
                r_p      <= P_W'(a) * P_W'(b);
                r_p_last <= in_last;
                r_relu_q <= relu_en;
            end
        end
    end

    // Stage 2: accumulate, count terms, and on the last term publish the result and restart at 0
    // so a following sequence can start with no bubble. Clear aborts without touching res.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_term_cnt <= '0;
            res        <= '0;
            res_vld    <= 1'b0;
            ovf        <= 1'b0;
            cnt        <= '0;
        end else begin
            res_vld <= 1'b0;
            if (!clr_n) begin
                r_state    <= IDLE;
                r_acc      <= '0;
                r_term_cnt <= '0;
            end else if (r_p_vld) begin
                if (r_p_last) begin
                    r_state    <= IDLE;
                    r_acc      <= '0;
                    r_term_cnt <= '0;
                    res        <= w_res;
                    ovf        <= w_ovf;
                    cnt        <= w_cnt_inc;
                    res_vld    <= 1'b1;
                end else begin
                    r_state    <= ACCUM;
                    r_acc      <= w_sum;
                    r_term_cnt <= w_cnt_inc;
                end
            end
        end
    end

endmodule
